// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the UART frame controller.
// Frame format: HDR, ADDR, LEN, LEN payload bytes, CSUM where
// CSUM = (ADDR + LEN + sum(payload)) mod 256.
package uart_frame_pkg;

  localparam logic [7:0] FRAME_HDR = 8'h55;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StPay,
    StCsum,
    StCommit
  } state_e;

  localparam logic [2:0] ERR_LEN  = 3'd1;
  localparam logic [2:0] ERR_CSUM = 3'd2;
  localparam logic [2:0] ERR_TMO  = 3'd4;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-in / register-write-out bundle of the frame controller.
//   master : the frame controller (consumes rx bytes, drives writes and status)
//   slave  : the environment (UART receiver byte source and register bus)
interface uart_rx_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [2:0] err_code;
  logic       rx_drop;
  logic       busy;

  modport master (
    input  rx_data, rx_done, wr_ready,
    output wr_valid, wr_addr, wr_data, frame_ok, frame_err, err_code, rx_drop, busy
  );

  modport slave (
    output rx_data, rx_done, wr_ready,
    input  wr_valid, wr_addr, wr_data, frame_ok, frame_err, err_code, rx_drop, busy
  );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 registers, one synchronous write port and a
// combinational read port. Contents are deliberately not reset.
// Ports:
//   i_clk      clock
//   i_we       write enable
//   i_wr_idx   write index
//   i_wr_data  write data
//   i_rd_idx   read index
//   o_rd_data  read data (0 for an out-of-range index)
module uart_frame_buf #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [7:0] i_wr_idx,
  input  logic [7:0] i_wr_data,
  input  logic [7:0] i_rd_idx,
  output logic [7:0] o_rd_data
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0] r_mem [MAX_LEN];

  always_ff @(posedge i_clk) begin
    if (i_we && (i_wr_idx < 8'(MAX_LEN))) begin
      r_mem[i_wr_idx[IdxW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = (i_rd_idx < 8'(MAX_LEN)) ? r_mem[i_rd_idx[IdxW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART byte receiver. Parses HDR/ADDR/LEN/payload/
// CSUM frames, buffers the payload and, only after the checksum matches,
// replays it as address/data writes over a valid/ready handshake.
// Optional feature: define UART_FRAME_TIMEOUT_EN to build the inter-byte
// timeout (error 4 after TIMEOUT_CYC silent cycles mid-frame).
// Ports:
//   Clk    system clock
//   Reset  asynchronous active-high reset
//   bus    uart_rx_frame_ctrl_if.master: rx_data/rx_done in, wr_* handshake,
//          frame_ok/frame_err/err_code/rx_drop/busy status (all registered)
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  uart_rx_frame_ctrl_if.master  bus
);

  state_e     r_state;
  logic [7:0] r_addr, r_len, r_idx, r_csum;
  logic       r_wr_valid, r_frame_ok, r_frame_err, r_rx_drop, r_busy;
  logic [7:0] r_wr_addr, r_wr_data;
  logic [2:0] r_err_code;

  logic       w_buf_we;
  logic [7:0] w_rd_idx, w_rd_data;
  logic       w_tmo_exp;

  // Read address looks one entry ahead so wr_data can be registered:
  // entry 0 while checking CSUM, entry idx+1 while committing.
  assign w_rd_idx = (r_state == StCommit) ? (r_idx + 8'd1) : 8'd0;
  assign w_buf_we = (r_state == StPay) && bus.rx_done;

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .i_clk     (Clk),
    .i_we      (w_buf_we),
    .i_wr_idx  (r_idx),
    .i_wr_data (bus.rx_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  logic [31:0] r_tmo;
  assign w_tmo_exp = (r_tmo >= (32'(TIMEOUT_CYC) - 32'd1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYC;
  assign w_tmo_exp    = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= StIdle;
      r_addr      <= 8'h00;
      r_len       <= 8'h00;
      r_idx       <= 8'h00;
      r_csum      <= 8'h00;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= 8'h00;
      r_wr_data   <= 8'h00;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 3'd0;
      r_rx_drop   <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      r_tmo       <= 32'd0;
`endif
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 3'd0;
      r_rx_drop   <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      // Counts silent cycles mid-frame; any byte restarts it.
      if ((r_state inside {StAddr, StLen, StPay, StCsum}) && !bus.rx_done) begin
        r_tmo <= r_tmo + 32'd1;
      end else begin
        r_tmo <= 32'd0;
      end
`endif
      case (r_state)
        StIdle: begin
          if (bus.rx_done && (bus.rx_data == FRAME_HDR)) begin
            r_state <= StAddr;
            r_busy  <= 1'b1;
          end
        end
        StAddr: begin
          if (bus.rx_done) begin
            r_addr  <= bus.rx_data;
            r_csum  <= bus.rx_data;
            r_state <= StLen;
          end
        end
        StLen: begin
          if (bus.rx_done) begin
            if ((bus.rx_data == 8'h00) || (bus.rx_data > 8'(MAX_LEN))) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_LEN;
              r_state     <= StIdle;
              r_busy      <= 1'b0;
            end else begin
              r_len   <= bus.rx_data;
              r_csum  <= r_csum + bus.rx_data;
              r_idx   <= 8'h00;
              r_state <= StPay;
            end
          end
        end
        StPay: begin
          if (bus.rx_done) begin
            r_csum <= r_csum + bus.rx_data;
            r_idx  <= r_idx + 8'd1;
            if ((r_idx + 8'd1) == r_len) begin
              r_state <= StCsum;
            end
          end
        end
        StCsum: begin
          if (bus.rx_done) begin
            if (bus.rx_data == r_csum) begin
              r_idx      <= 8'h00;
              r_wr_valid <= 1'b1;
              r_wr_addr  <= r_addr;
              r_wr_data  <= w_rd_data;
              r_state    <= StCommit;
            end else begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_CSUM;
              r_state     <= StIdle;
              r_busy      <= 1'b0;
            end
          end
        end
        StCommit: begin
          if (bus.rx_done) begin
            r_rx_drop <= 1'b1;
          end
          if (r_wr_valid && bus.wr_ready) begin
            if (r_idx == (r_len - 8'd1)) begin
              r_wr_valid <= 1'b0;
              r_frame_ok <= 1'b1;
              r_state    <= StIdle;
              r_busy     <= 1'b0;
            end else begin
              r_idx     <= r_idx + 8'd1;
              r_wr_addr <= r_wr_addr + 8'd1;
              r_wr_data <= w_rd_data;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
      // Timeout overrides the hold-in-state; a byte in the same cycle wins.
      if ((r_state inside {StAddr, StLen, StPay, StCsum}) && !bus.rx_done && w_tmo_exp) begin
        r_frame_err <= 1'b1;
        r_err_code  <= ERR_TMO;
        r_state     <= StIdle;
        r_busy      <= 1'b0;
      end
    end
  end

  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.frame_ok  = r_frame_ok;
  assign bus.frame_err = r_frame_err;
  assign bus.err_code  = r_err_code;
  assign bus.rx_drop   = r_rx_drop;
  assign bus.busy      = r_busy;

endmodule
